// File: rtl/if_id_fetch_queue_pkg.sv
// if_id_fetch_queue_pkg: shared constants and entry field layout for the IF/ID fetch queue
package if_id_fetch_queue_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int PC_W_DEF = 32;
  localparam int INSTR_W_DEF = 32;
  localparam int B_ADDR_OFS = 0;
  function automatic int instr_ofs(input int pc_w);
    return B_ADDR_OFS + pc_w;
  endfunction
  function automatic int pc_ofs(input int pc_w, input int instr_w);
    return instr_ofs(pc_w) + instr_w;
  endfunction
endpackage

// File: rtl/if_id_fetch_queue_mem.sv
// fetch_queue_mem: unreset register array, one sync write port and one async read port
module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W = 96
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_fetch_queue.sv
// if_id_fetch_queue: buffers fetched {pc, instr, b_addr} words for decode with valid/ready and flush
module if_id_fetch_queue
  import if_id_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid,
  input  logic [PC_W-1:0]            if_pc,
  input  logic [INSTR_W-1:0]         if_instr,
  input  logic [PC_W-1:0]            if_b_addr,
  output logic                       if_stall,
  input  logic                       flush,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [PC_W-1:0]            id_pc,
  output logic [INSTR_W-1:0]         id_instr,
  output logic [PC_W-1:0]            id_b_addr,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int IO = instr_ofs(PC_W);
  localparam int PO = pc_ofs(PC_W, INSTR_W);
  localparam int EW = PO + PC_W;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [EW-1:0] wr_word, rd_word;
  logic fl, push, pop, empty;
  // X on control inputs must never move state, so qualify with case equality
  assign fl = flush === 1'b1;
  assign empty = count == '0;
  assign push = (if_valid === 1'b1) & ~if_stall & ~fl;
  assign pop = id_valid & (id_ready === 1'b1) & ~fl;
  assign wr_word = {if_pc, if_instr, if_b_addr};
  fetch_queue_mem #(.DEPTH(DEPTH), .W(EW)) u_mem (
    .clk(clk),
    .we(push),
    .waddr(wr_ptr),
    .wdata(wr_word),
    .raddr(rd_ptr),
    .rdata(rd_word)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (fl) begin
      rd_ptr <= wr_ptr;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_comb begin
    if_stall = count == FULL;
    id_valid = ~empty;
    occupancy = count;
    id_pc = empty ? '0 : rd_word[PO +: PC_W];
    id_instr = empty ? INSTR_W'(NOP_INSTR) : rd_word[IO +: INSTR_W];
    id_b_addr = empty ? '0 : rd_word[B_ADDR_OFS +: PC_W];
  end
endmodule

// File: tb/tb_if_id_fetch_queue.sv
// tb_if_id_fetch_queue: scoreboard bench for the IF/ID fetch queue
module tb_if_id_fetch_queue;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 0;
  logic if_valid = 0, flush = 0, id_ready = 0;
  logic [31:0] if_pc = 0, if_instr = 0, if_b_addr = 0;
  logic if_stall, id_valid;
  logic [31:0] id_pc, id_instr, id_b_addr;
  logic [2:0] occupancy;
  logic [95:0] sb[$];
  int checks = 0, errors = 0;

  if_id_fetch_queue #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_b_addr(if_b_addr), .if_stall(if_stall), .flush(flush), .id_valid(id_valid),
    .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr), .id_b_addr(id_b_addr),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task drive(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic rdy, input logic fl);
    if_valid = v;
    if_pc = pc;
    if_instr = ins;
    if_b_addr = pc + 32'h40;
    id_ready = rdy;
    flush = fl;
  endtask

  task tick;
    bit p, q;
    if (flush === 1'b1) sb.delete();
    else begin
      q = (sb.size() != 0) && (id_ready === 1'b1);
      p = (if_valid === 1'b1) && (sb.size() < DEPTH);
      if (q) void'(sb.pop_front());
      if (p) sb.push_back({if_pc, if_instr, if_b_addr});
    end
    @(posedge clk);
    #1;
  endtask

  task drain;
    while (sb.size() != 0) begin
      checks++;
      if ({id_valid, id_pc, id_instr, id_b_addr} !== {1'b1, sb[0]}) begin
        errors++;
        $display("FAIL drain_head: got v=%b %h exp %h", id_valid, {id_pc, id_instr, id_b_addr}, sb[0]);
      end
      drive(0, 0, 0, 1, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task test_reset;
    checks++;
    if ({id_valid, if_stall, occupancy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got v=%b stall=%b occ=%0d exp 0/0/0", id_valid, if_stall, occupancy);
    end
    checks++;
    if ({id_pc, id_instr, id_b_addr} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got %h exp 0", {id_pc, id_instr, id_b_addr});
    end
  endtask

  task test_single;
    drive(1, 32'h3000, 32'h2008_0005, 0, 0);
    tick();
    checks++;
    if ({id_valid, id_pc, id_instr, occupancy} !== {1'b1, 32'h3000, 32'h2008_0005, 3'd1}) begin
      errors++;
      $display("FAIL single_push: got v=%b pc=%h ins=%h occ=%0d exp 1/3000/20080005/1", id_valid, id_pc, id_instr, occupancy);
    end
    checks++;
    if (id_b_addr !== sb[0][31:0]) begin
      errors++;
      $display("FAIL single_baddr: got %h exp %h", id_b_addr, sb[0][31:0]);
    end
    drive(0, 0, 0, 1, 0);
    tick();
    checks++;
    if ({id_valid, id_instr, occupancy} !== {1'b0, 32'h0, 3'd0}) begin
      errors++;
      $display("FAIL single_pop: got v=%b ins=%h occ=%0d exp 0/0/0", id_valid, id_instr, occupancy);
    end
  endtask

  task test_full;
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h3000 + 4 * i, 32'hA000_0000 + i, 0, 0);
      tick();
    end
    checks++;
    if ({occupancy, if_stall} !== {3'd4, 1'b1}) begin
      errors++;
      $display("FAIL full: got occ=%0d stall=%b exp 4/1", occupancy, if_stall);
    end
    drive(1, 32'h3010, 32'hA000_0004, 0, 0);
    tick();
    checks++;
    if ({occupancy, id_pc} !== {3'd4, 32'h3000} || sb.size() != 4) begin
      errors++;
      $display("FAIL full_ignore: got occ=%0d pc=%h exp 4/00003000", occupancy, id_pc);
    end
    drive(1, 32'h3010, 32'hA000_0004, 1, 0);
    tick();
    checks++;
    if ({occupancy, if_stall, id_pc} !== {3'd3, 1'b0, 32'h3004}) begin
      errors++;
      $display("FAIL full_pop_blocks_push: got occ=%0d stall=%b pc=%h exp 3/0/00003004", occupancy, if_stall, id_pc);
    end
    drive(1, 32'h3010, 32'hA000_0004, 0, 0);
    tick();
    checks++;
    if (occupancy !== 3'd4) begin
      errors++;
      $display("FAIL full_repush: got occ=%0d exp 4", occupancy);
    end
    drain();
  endtask

  task test_stream;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h3000 + 4 * i, 32'hB000_0000 + i, 0, 0);
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      drive(1, 32'h300C + 4 * i, 32'hB000_0003 + i, 1, 0);
      checks++;
      if (id_pc !== 32'h3000 + 4 * i || {id_pc, id_instr, id_b_addr} !== sb[0]) begin
        errors++;
        $display("FAIL stream_head[%0d]: got %h exp pc %h", i, {id_pc, id_instr, id_b_addr}, 32'h3000 + 4 * i);
      end
      tick();
      checks++;
      if (occupancy !== 3'd3) begin
        errors++;
        $display("FAIL stream_occ[%0d]: got %0d exp 3", i, occupancy);
      end
    end
    drain();
  endtask

  task test_flush;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h3040 + 4 * i, 32'hC000_0000 + i, 0, 0);
      tick();
    end
    drive(1, 32'h3200, 32'hC000_00FF, 1, 1);
    tick();
    checks++;
    if ({occupancy, id_valid, if_stall} !== {3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL flush: got occ=%0d v=%b stall=%b exp 0/0/0", occupancy, id_valid, if_stall);
    end
    drive(1, 32'h3100, 32'hC000_0100, 0, 0);
    tick();
    checks++;
    if ({id_valid, id_pc, id_instr, occupancy} !== {1'b1, 32'h3100, 32'hC000_0100, 3'd1}) begin
      errors++;
      $display("FAIL flush_next_head: got v=%b pc=%h ins=%h occ=%0d exp 1/3100/c0000100/1", id_valid, id_pc, id_instr, occupancy);
    end
    drain();
  endtask

  task test_async_reset;
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h3080 + 4 * i, 32'hD000_0000 + i, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    #2 rst = 0;
    sb.delete();
    #1;
    checks++;
    if ({id_valid, if_stall, occupancy} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b stall=%b occ=%0d exp 0/0/0", id_valid, if_stall, occupancy);
    end
    #3 rst = 1;
    tick();
    test_single();
  endtask

  task test_x;
    drive(1, 32'h30C0, 32'hE000_0000, 0, 0);
    tick();
    drive(1'bx, 32'h30C4, 32'hE000_0001, 0, 1'bx);
    tick();
    checks++;
    if ({occupancy, id_pc} !== {3'd1, 32'h30C0}) begin
      errors++;
      $display("FAIL x_inputs: got occ=%0d pc=%h exp 1/000030c0", occupancy, id_pc);
    end
    drive(0, 0, 0, 0, 0);
    drain();
    checks++;
    if ({id_valid, occupancy} !== 4'b0) begin
      errors++;
      $display("FAIL x_no_write: got v=%b occ=%0d exp 0/0", id_valid, occupancy);
    end
  endtask

  initial begin
    #1;
    test_reset();
    #11 rst = 1;
    @(posedge clk);
    #1;
    test_single();
    test_full();
    test_stream();
    test_flush();
    test_async_reset();
    test_x();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
